opcode_exec: RTL and testbench

OPCODE_EXEC -- requirements
Module: opcode_exec

---
 rtl/opcode_exec_pkg.sv | 61 ++++++
 rtl/opcode_exec_mul.sv | 60 ++++++
 rtl/opcode_exec.sv | 176 +++++++++++++++++
 tb/tb_opcode_exec.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_exec_pkg.sv
// rtl/opcode_exec_pkg.sv - opcode field layout, function codes, operand encodings and FSM states
package opcode_exec_pkg;

    // Opcode field positions and widths
    localparam int FN_LSB  = 0;
    localparam int FN_W    = 4;
    localparam int DST_LSB = 4;
    localparam int DST_W   = 2;
    localparam int SRC_LSB = 6;
    localparam int SRC_W   = 3;
    localparam int RSV_LSB = 9;
    localparam int RSV_W   = 3;
    localparam int OP_BITS = 12;

    // Function codes
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_SHL  = 4'd3;
    localparam logic [3:0] FN_SHR  = 4'd4;
    localparam logic [3:0] FN_NEG  = 4'd5;
    localparam logic [3:0] FN_MOVE = 4'd6;
    localparam logic [3:0] FN_NOP  = 4'd7;
    localparam logic [3:0] FN_CLR  = 4'd8;
    localparam logic [3:0] FN_MUL  = 4'd9;

    // Destination encodings
    localparam logic [1:0] DST_A   = 2'd0;
    localparam logic [1:0] DST_B   = 2'd1;
    localparam logic [1:0] DST_C   = 2'd2;
    localparam logic [1:0] DST_BAD = 2'd3;

    // Source encodings
    localparam logic [2:0] SRC_X    = 3'd0;
    localparam logic [2:0] SRC_Y    = 3'd1;
    localparam logic [2:0] SRC_AOUT = 3'd2;
    localparam logic [2:0] SRC_BOUT = 3'd3;
    localparam logic [2:0] SRC_COUT = 3'd4;

    // Multiplier operand width (low byte of B and C)
    localparam int MUL_OPND_W = 8;

`ifdef OPCODE_EXEC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_DONE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0
    } state_e;
`endif

    // Field-level legality shared by every function code
    function automatic logic fields_legal(input logic [1:0] dst, input logic [2:0] src,
                                          input logic [2:0] rsv);
        return (rsv == 3'd0) && (dst != DST_BAD) && (src <= SRC_COUT);
    endfunction

endpackage

// File: rtl/opcode_exec_mul.sv
// rtl/opcode_exec_mul.sv - iterative signed 8x8 shift-add multiplier, one partial product per cycle
module opcode_exec_mul
    import opcode_exec_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MUL_OPND_W-1:0] mcand,
    input  logic [MUL_OPND_W-1:0] mplier,
    output logic                  busy,
    output logic                  last,
    output logic [W-1:0]          result
);

    logic [W-1:0]          acc;
    logic [W-1:0]          mc_sh;
    logic [MUL_OPND_W-1:0] mp_sh;
    logic [2:0]            step;
    logic                  run;
    logic [W-1:0]          addend;

    // The multiplier's top bit carries weight -2^7, so the last partial product is subtracted
    always_comb begin
        addend = '0;
        if (mp_sh[0])
            addend = (step == 3'd7) ? (~mc_sh + 1'b1) : mc_sh;
    end

    // result already includes the current step, so it is final while last is high
    assign result = acc + addend;
    assign busy   = run;
    assign last   = run && (step == 3'd7);

    // Load operands on start, then one shift-add step per cycle for eight cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mc_sh <= '0;
            mp_sh <= '0;
            step  <= '0;
            run   <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            mc_sh <= {{(W-MUL_OPND_W){mcand[MUL_OPND_W-1]}}, mcand};
            mp_sh <= mplier;
            step  <= '0;
            run   <= 1'b1;
        end else if (run) begin
            acc   <= result;
            mc_sh <= mc_sh << 1;
            mp_sh <= mp_sh >> 1;
            step  <= step + 3'd1;
            if (step == 3'd7)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/opcode_exec.sv
// rtl/opcode_exec.sv - opcode decoder/executor over A/B/C and Aout/Bout/Cout; MUL built only with OPCODE_EXEC_MUL_EN
module opcode_exec
    import opcode_exec_pkg::*;
#(
    parameter int W   = 16,
    parameter int OPW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [W-1:0]   Mem_Dat_X,
    input  logic [W-1:0]   Mem_Dat_Y,
    output logic [W-1:0]   Aout,
    output logic [W-1:0]   Bout,
    output logic [W-1:0]   Cout,
    output logic           done,
    output logic           illegal
);

    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic [W-1:0] reg_c;
    logic         ready_en;
    state_e       state;
    state_e       state_next;

    logic [FN_W-1:0]  fn;
    logic [DST_W-1:0] dst;
    logic [SRC_W-1:0] src;
    logic [RSV_W-1:0] rsv;
    logic             fn_known;
    logic             op_legal;
    logic             is_mul;
    logic             accept;
    logic [W-1:0]     src_val;

    assign fn  = opcode[FN_LSB  +: FN_W];
    assign dst = opcode[DST_LSB +: DST_W];
    assign src = opcode[SRC_LSB +: SRC_W];
    assign rsv = opcode[RSV_LSB +: RSV_W];

`ifdef OPCODE_EXEC_MUL_EN
    assign fn_known = (fn <= FN_MUL);
`else
    assign fn_known = (fn <= FN_CLR);
`endif

    assign op_legal = fn_known && fields_legal(dst, src, rsv);
    assign accept   = op_valid && op_ready;

`ifdef OPCODE_EXEC_MUL_EN
    logic         mul_start;
    logic         mul_busy;
    logic         mul_last;
    logic [W-1:0] mul_result;

    assign is_mul    = op_legal && (fn == FN_MUL);
    assign mul_start = accept && is_mul;

    opcode_exec_mul #(.W(W)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .mcand  (reg_b[MUL_OPND_W-1:0]),
        .mplier (reg_c[MUL_OPND_W-1:0]),
        .busy   (mul_busy),
        .last   (mul_last),
        .result (mul_result)
    );
`else
    assign is_mul = 1'b0;
`endif

    // MOVE source select; output registers are read before this edge's updates
    always_comb begin
        src_val = '0;
        case (src)
            SRC_X:    src_val = Mem_Dat_X;
            SRC_Y:    src_val = Mem_Dat_Y;
            SRC_AOUT: src_val = Aout;
            SRC_BOUT: src_val = Bout;
            SRC_COUT: src_val = Cout;
            default:  src_val = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next state: only a legal MUL leaves IDLE
    always_comb begin
        state_next = state;
`ifdef OPCODE_EXEC_MUL_EN
        case (state)
            ST_IDLE:     if (accept && is_mul) state_next = ST_MUL_RUN;
            ST_MUL_RUN:  if (mul_last)         state_next = ST_MUL_DONE;
            ST_MUL_DONE:                       state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
`else
        state_next = ST_IDLE;
`endif
    end

    // FSM outputs: ready only in IDLE once reset has been released for an edge
    always_comb begin
        op_ready = ready_en && (state == ST_IDLE);
`ifdef OPCODE_EXEC_MUL_EN
        op_ready = ready_en && (state == ST_IDLE) && !mul_busy;
`endif
    end

    // Register file, result registers, done pulse and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            Aout     <= '0;
            Bout     <= '0;
            Cout     <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done     <= 1'b0;
            if (accept && !is_mul) begin
                done <= 1'b1;
                if (!op_legal) begin
                    illegal <= 1'b1;
                end else begin
                    case (fn)
                        FN_ADD:  Aout <= reg_a + reg_c;
                        FN_SUB:  Aout <= reg_a - reg_c;
                        FN_AND:  Aout <= reg_b & {W{reg_c[0]}};
                        FN_SHL:  Bout <= reg_b << 1;
                        FN_SHR:  Cout <= $signed(reg_c) >>> 1;
                        FN_NEG:  Bout <= ~reg_b + 1'b1;
                        FN_MOVE: begin
                            case (dst)
                                DST_A:   reg_a <= src_val;
                                DST_B:   reg_b <= src_val;
                                DST_C:   reg_c <= src_val;
                                default: ;
                            endcase
                        end
                        FN_CLR: begin
                            reg_a <= '0;
                            reg_b <= '0;
                            reg_c <= '0;
                            Aout  <= '0;
                            Bout  <= '0;
                            Cout  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef OPCODE_EXEC_MUL_EN
            if ((state == ST_MUL_RUN) && mul_last) begin
                Aout <= mul_result;
                done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_opcode_exec.sv
// tb/tb_opcode_exec.sv - scoreboard bench for opcode_exec with a behavioural reference model
module tb_opcode_exec;

    localparam int W   = 16;
    localparam int OPW = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [OPW-1:0] opcode = '0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [W-1:0]   mem_x = '0;
    logic [W-1:0]   mem_y = '0;
    logic [W-1:0]   aout, bout, cout;
    logic           done, illegal;

    always #5 clk = ~clk;

    opcode_exec #(.W(W), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .Mem_Dat_X (mem_x),
        .Mem_Dat_Y (mem_y),
        .Aout      (aout),
        .Bout      (bout),
        .Cout      (cout),
        .done      (done),
        .illegal   (illegal)
    );

    typedef struct {
        logic [W-1:0] ao;
        logic [W-1:0] bo;
        logic [W-1:0] co;
        logic         ill;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   busy_left = 0;

    logic [W-1:0] m_a, m_b, m_c, m_ao, m_bo, m_co;
    logic         m_ill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_c = '0; m_ao = '0; m_bo = '0; m_co = '0;
        m_ill = 1'b0;
        busy_left = 0;
    endtask

    // Reference semantics computed from the field values with plain arithmetic
    task automatic model_exec(input logic [OPW-1:0] op, input logic [W-1:0] x,
                              input logic [W-1:0] y, output bit took_mul);
        int fn, dst, src, rsv, p;
        bit mul_built, ok;
        logic [W-1:0] v;
        logic signed [7:0] sb8, sc8;
        fn  = int'(op) % 16;
        dst = (int'(op) / 16) % 4;
        src = (int'(op) / 64) % 8;
        rsv = int'(op) / 512;
`ifdef OPCODE_EXEC_MUL_EN
        mul_built = 1'b1;
`else
        mul_built = 1'b0;
`endif
        ok = (rsv == 0) && (dst != 3) && (src <= 4) && (fn <= 8 || (fn == 9 && mul_built));
        took_mul = ok && (fn == 9);
        if (!ok) begin
            m_ill = 1'b1;
        end else begin
            case (fn)
                0: m_ao = W'(int'(m_a) + int'(m_c));
                1: m_ao = W'(int'(m_a) - int'(m_c));
                2: m_ao = m_c[0] ? m_b : '0;
                3: m_bo = W'(int'(m_b) * 2);
                4: m_co = W'(int'(m_c) / 2 + (m_c[W-1] ? 32768 : 0));
                5: m_bo = W'(0 - int'(m_b));
                6: begin
                    case (src)
                        0: v = x;
                        1: v = y;
                        2: v = m_ao;
                        3: v = m_bo;
                        default: v = m_co;
                    endcase
                    if (dst == 0) m_a = v;
                    else if (dst == 1) m_b = v;
                    else m_c = v;
                end
                8: begin
                    m_a = '0; m_b = '0; m_c = '0; m_ao = '0; m_bo = '0; m_co = '0;
                end
                9: begin
                    sb8 = m_b[7:0];
                    sc8 = m_c[7:0];
                    p = int'(sb8) * int'(sc8);
                    m_ao = W'(p);
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input int n);
        op_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (busy_left > 0) busy_left--;
        end
    endtask

    // Present an op at a negedge, hold it until accepted, push the expected retirement
    task automatic issue(input logic [OPW-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int waits, exp_wait;
        bit took_mul;
        exp_t e;
        waits = 0;
        exp_wait = busy_left;
        opcode = op; mem_x = x; mem_y = y; op_valid = 1'b1;
        while (!op_ready && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        vectors++;
        if (waits != exp_wait) begin
            miscompares++;
            $display("FAIL ready_wait op=%h: waited %0d cycles, expected %0d", op, waits, exp_wait);
        end
        if (!op_ready) begin
            op_valid = 1'b0;
            busy_left = 0;
            return;
        end
        model_exec(op, x, y, took_mul);
        e.ao = m_ao; e.bo = m_bo; e.co = m_co; e.ill = m_ill;
        e.due = cyc + (took_mul ? 9 : 1);
        sb.push_back(e);
        busy_left = took_mul ? 9 : 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_aout", aout, '0);
        chk("rst_bout", bout, '0);
        chk("rst_cout", cout, '0);
        chk("rst_flags", {13'd0, done, illegal, op_ready}, '0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("ready_before_edge", {15'd0, op_ready}, 16'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", {15'd0, op_ready}, 16'd1);
        @(negedge clk);
    endtask

    // Monitor: every done retires the oldest expected op
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_aout", aout, e.ao);
                    chk("sb_bout", bout, e.bo);
                    chk("sb_cout", cout, e.co);
                    chk("sb_illegal", {15'd0, illegal}, {15'd0, e.ill});
                    chk("done_cycle", W'(cyc), W'(e.due));
                end
            end
        end
    end

    task automatic rand_op(output logic [OPW-1:0] op);
        int fn, dst, src, rsv;
        fn  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
        dst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        src = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        rsv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 7)) : 0;
        op = OPW'(rsv * 512 + src * 64 + dst * 16 + fn);
    endtask

    initial begin
        logic [OPW-1:0] op;
        @(negedge clk);
        do_reset();

        // Wrap-around add, done one cycle after acceptance
        issue(12'h006, 16'hFFFF, 16'h0000);
        issue(12'h026, 16'h0001, 16'h0000);
        issue(12'h000, 16'h0000, 16'h0000);
        chk("add_wrap", aout, 16'h0000);
        chk("add_done", {15'd0, done}, 16'd1);

        // Arithmetic shift right and shift left with zero fill
        issue(12'h026, 16'h8002, 16'h0000);
        issue(12'h004, 16'h0000, 16'h0000);
        chk("shr_arith", cout, 16'hC001);
        issue(12'h016, 16'h8001, 16'h0000);
        issue(12'h003, 16'h0000, 16'h0000);
        chk("shl_zero", bout, 16'h0002);

        // Back-to-back ops including MOVE Aout->A reading the old Aout
        issue(12'h006, 16'h1234, 16'h0000);
        issue(12'h000, 16'h0000, 16'h0000);
        issue(12'h086, 16'h0000, 16'h0000);
        issue(12'h000, 16'h0000, 16'h0000);
        issue(12'h001, 16'h0000, 16'h0000);
        issue(12'h005, 16'h0000, 16'h0000);
        issue(12'h002, 16'h0000, 16'h0000);

        // Reserved bits set: illegal, registers untouched, done still pulsed
        issue(12'h200, 16'h0000, 16'h0000);
        chk("illegal_set", {15'd0, illegal}, 16'd1);
        issue(12'h000, 16'h0000, 16'h0000);
        tick(2);

        // LOAD X->B, LOAD Y->C, MUL
        do_reset();
        issue(12'h016, 16'hFFF8, 16'hFFF1);
        issue(12'h066, 16'hFFF8, 16'hFFF1);
        issue(12'h009, 16'h0000, 16'h0000);
        tick(9);
`ifdef OPCODE_EXEC_MUL_EN
        chk("mul_result", aout, 16'h0078);
`else
        chk("mul_absent", {15'd0, illegal}, 16'd1);
`endif
        issue(12'h007, 16'h0000, 16'h0000);
        tick(2);

        // Reset in the 4th MUL_RUN cycle abandons the op
        do_reset();
        issue(12'h016, 16'h0033, 16'h0000);
        issue(12'h066, 16'h0000, 16'h0055);
        issue(12'h009, 16'h0000, 16'h0000);
        tick(3);
        do_reset();
        tick(12);

        // Randomised rounds, each starting from reset
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                rand_op(op);
                issue(op, 16'($urandom), 16'($urandom));
                if ($urandom_range(0, 4) == 0) tick(int'($urandom_range(1, 3)));
            end
            tick(12);
            chk("sb_drained", 16'(sb.size()), 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
